// File: rtl/aes128_dec_key_sched.sv
// ---------------------------------------------------------------------------
// aes128_dec_key_sched
//
// Decryption round-key scheduler for the AES-128 core.  A cipher key is
// expanded forward (one round per cycle) to obtain round key 10, which is
// cached.  For each decrypted block the scheduler drives the external
// inverse key-expansion unit so that round keys 10 down to 0 stream out
// under a valid/ready handshake.
//
// Ports
//   clk_sys          in   1    system clock, rising edge
//   rst              in   1    synchronous active-high reset
//   key_load         in   1    strobe: capture cipher_key, start expansion
//   cipher_key       in   128  cipher key, word 0 in [127:96]
//   key_ready        out  1    cached round key 10 is valid
//   dec_start        in   1    request one round-key sequence (IDLE only)
//   dec_ready        out  1    scheduler is in IDLE
//   round_key_10     out  128  cached round key 10 (to inverse unit)
//   inv_round_num    out  4    round_num of the inverse unit
//   inv_rkey_en      out  1    rkey_en of the inverse unit
//   round_key_inv_in in   128  round_key_inv_out of the inverse unit
//   rk_valid         out  1    rk_data / rk_index valid
//   rk_ready         in   1    consumer accepts the presented key
//   rk_index         out  4    round index of rk_data (10..0)
//   rk_data          out  128  round key
//   dec_done         out  1    one-cycle pulse after key 0 is transferred
// ---------------------------------------------------------------------------
module aes128_dec_key_sched (
  input  logic         clk_sys,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] cipher_key,
  output logic         key_ready,
  input  logic         dec_start,
  output logic         dec_ready,
  output logic [127:0] round_key_10,
  output logic [3:0]   inv_round_num,
  output logic         inv_rkey_en,
  input  logic [127:0] round_key_inv_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_index,
  output logic [127:0] rk_data,
  output logic         dec_done
);

  typedef enum logic [2:0] {
    ST_NOKEY  = 3'd0,
    ST_EXPAND = 3'd1,
    ST_IDLE   = 3'd2,
    ST_K10    = 3'd3,
    ST_INV    = 3'd4
  } state_t;

  // Forward S-box, byte 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8*(255 - int'(x)) +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    case (n)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_t       r_state, w_state_next;
  logic [3:0]   r_cnt, w_cnt_next;
  logic [127:0] r_key, w_key_next;
  logic [127:0] r_rk10, w_rk10_next;
  logic         r_key_ready, w_key_ready_next;
  logic         r_dec_done, w_dec_done_next;

  // One forward expansion step on r_key using rcon(r_cnt).
  logic [31:0]  w_rot, w_sub, w_t;
  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [127:0] w_fwd;

  assign w_rot = {r_key[23:0], r_key[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      assign w_sub[gi*8 +: 8] = sbox(w_rot[gi*8 +: 8]);
    end
  endgenerate

  assign w_t   = w_sub ^ {rcon(r_cnt), 24'h0};
  assign w_w0  = r_key[127:96] ^ w_t;
  assign w_w1  = r_key[95:64]  ^ w_w0;
  assign w_w2  = r_key[63:32]  ^ w_w1;
  assign w_w3  = r_key[31:0]   ^ w_w2;
  assign w_fwd = {w_w0, w_w1, w_w2, w_w3};

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state     <= ST_NOKEY;
      r_cnt       <= 4'd0;
      r_key       <= '0;
      r_rk10      <= '0;
      r_key_ready <= 1'b0;
      r_dec_done  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_key       <= w_key_next;
      r_rk10      <= w_rk10_next;
      r_key_ready <= w_key_ready_next;
      r_dec_done  <= w_dec_done_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_key_next       = r_key;
    w_rk10_next      = r_rk10;
    w_key_ready_next = r_key_ready;
    w_dec_done_next  = 1'b0;

    dec_ready     = 1'b0;
    rk_valid      = 1'b0;
    rk_index      = 4'd0;
    rk_data       = '0;
    inv_round_num = 4'd0;
    inv_rkey_en   = 1'b0;

    case (r_state)
      ST_NOKEY: begin
      end

      ST_EXPAND: begin
        w_key_next = w_fwd;
        w_cnt_next = r_cnt + 4'd1;
        if (r_cnt == 4'd10) begin
          w_rk10_next      = w_fwd;
          w_key_ready_next = 1'b1;
          w_cnt_next       = 4'd0;
          w_state_next     = ST_IDLE;
        end
      end

      ST_IDLE: begin
        dec_ready = 1'b1;
        if (dec_start) begin
          w_cnt_next   = 4'd0;
          w_state_next = ST_K10;
        end
      end

      // Key 10 comes straight from the cache; stepping the inverse unit
      // with round_num 0 makes it load key 9 from round_key_10.
      ST_K10: begin
        rk_valid    = 1'b1;
        rk_index    = 4'd10;
        rk_data     = r_rk10;
        inv_rkey_en = rk_ready;
        if (rk_ready) begin
          w_cnt_next   = 4'd1;
          w_state_next = ST_INV;
        end
      end

      // The inverse register holds key 10-cnt; it is only stepped on a
      // transfer so it stays put across consumer stalls.
      ST_INV: begin
        rk_valid      = 1'b1;
        rk_index      = 4'd10 - r_cnt;
        rk_data       = round_key_inv_in;
        inv_round_num = r_cnt;
        inv_rkey_en   = rk_ready & (r_cnt != 4'd10);
        if (rk_ready) begin
          if (r_cnt == 4'd10) begin
            w_cnt_next      = 4'd0;
            w_dec_done_next = 1'b1;
            w_state_next    = ST_IDLE;
          end else begin
            w_cnt_next = r_cnt + 4'd1;
          end
        end
      end

      default: begin
        w_state_next = ST_NOKEY;
      end
    endcase

    // A new key overrides everything, including a sequence in flight.
    if (key_load) begin
      w_state_next     = ST_EXPAND;
      w_key_next       = cipher_key;
      w_cnt_next       = 4'd1;
      w_key_ready_next = 1'b0;
      w_dec_done_next  = 1'b0;
    end
  end

  assign key_ready    = r_key_ready;
  assign round_key_10 = r_rk10;
  assign dec_done     = r_dec_done;

endmodule

// File: tb/tb_aes128_dec_key_sched.sv
// ---------------------------------------------------------------------------
// tb_aes128_dec_key_sched
//
// Bench for aes128_dec_key_sched.  Contains a behavioural inverse
// key-expansion unit, a stimulus process that pushes expected transfers,
// dec_done pulses and key-ready events into queues, and a monitor that
// pops and compares them whenever the DUT presents them.
// ---------------------------------------------------------------------------
module tb_aes128_dec_key_sched;

  logic         clk_sys = 1'b0;
  logic         rst;
  logic         key_load;
  logic [127:0] cipher_key;
  logic         key_ready;
  logic         dec_start;
  logic         dec_ready;
  logic [127:0] round_key_10;
  logic [3:0]   inv_round_num;
  logic         inv_rkey_en;
  logic [127:0] round_key_inv_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_index;
  logic [127:0] rk_data;
  logic         dec_done;

  always #5 clk_sys = ~clk_sys;

  aes128_dec_key_sched dut (
    .clk_sys          (clk_sys),
    .rst              (rst),
    .key_load         (key_load),
    .cipher_key       (cipher_key),
    .key_ready        (key_ready),
    .dec_start        (dec_start),
    .dec_ready        (dec_ready),
    .round_key_10     (round_key_10),
    .inv_round_num    (inv_round_num),
    .inv_rkey_en      (inv_rkey_en),
    .round_key_inv_in (round_key_inv_in),
    .rk_valid         (rk_valid),
    .rk_ready         (rk_ready),
    .rk_index         (rk_index),
    .rk_data          (rk_data),
    .dec_done         (dec_done)
  );

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK10_A = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  typedef struct {
    int           idx;
    logic [127:0] data;
    int           cyc;
  } rk_exp_t;

  typedef struct {
    int           cyc;
    logic [127:0] rk;
  } key_exp_t;

  rk_exp_t      q_rk[$];
  key_exp_t     q_key[$];
  int           q_done[$];
  logic [127:0] exp_rk [0:10];
  logic [7:0]   sb [0:255];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // ---------------- behavioural inverse key-expansion unit ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] tb_rcon(input int r);
    logic [7:0] t;
    t = 8'h01;
    for (int i = 1; i < r; i++) t = gmul(t, 8'h02);
    return t;
  endfunction

  function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, sub;
    w3  = k[31:0]  ^ k[63:32];
    w2  = k[63:32] ^ k[95:64];
    w1  = k[95:64] ^ k[127:96];
    rot = {w3[23:0], w3[31:24]};
    sub = {sb[rot[31:24]], sb[rot[23:16]], sb[rot[15:8]], sb[rot[7:0]]};
    w0  = k[127:96] ^ sub ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  logic [127:0] inv_reg;
  always @(posedge clk_sys) begin
    if (rst) inv_reg <= '0;
    else if (inv_rkey_en) begin
      if (inv_round_num == 4'd0) inv_reg <= inv_step(round_key_10, tb_rcon(10));
      else inv_reg <= inv_step(inv_reg, tb_rcon(10 - int'(inv_round_num)));
    end
  end
  assign round_key_inv_in = inv_reg;

  // ---------------- comparison helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    rk_exp_t  e;
    key_exp_t k;
    int       d;
    logic     prev_kr;
    prev_kr = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (rk_valid && rk_ready) begin
        $display("rk xfer cycle=%0d index=%0d data=%h", cyc, rk_index, rk_data);
        if (q_rk.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rk_unexpected: got index %0d at cycle %0d, expected no transfer", rk_index, cyc);
        end else begin
          e = q_rk.pop_front();
          chki("rk_index", int'(rk_index), e.idx);
          chk("rk_data", rk_data, e.data);
          chki("rk_cycle", cyc, e.cyc);
        end
      end
      if (rk_valid && !rk_ready) chki("inv_en_stall", int'(inv_rkey_en), 0);
      if (dec_done) begin
        $display("dec_done cycle=%0d", cyc);
        if (q_done.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL done_unexpected: got pulse at cycle %0d, expected none", cyc);
        end else begin
          d = q_done.pop_front();
          chki("done_cycle", cyc, d);
        end
      end
      if (key_ready && !prev_kr) begin
        $display("key_ready cycle=%0d rk10=%h", cyc, round_key_10);
        if (q_key.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL key_unexpected: got key_ready at cycle %0d, expected none", cyc);
        end else begin
          k = q_key.pop_front();
          chki("key_ready_cycle", cyc, k.cyc);
          chk("round_key_10", round_key_10, k.rk);
          chki("dec_ready_at_key", int'(dec_ready), 1);
        end
      end
      prev_kr = key_ready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_key_load(input logic [127:0] k, input logic [127:0] rk10);
    cipher_key = k;
    key_load   = 1'b1;
    q_key.push_back('{cyc: cyc + 11, rk: rk10});
    tick();
    key_load = 1'b0;
  endtask

  task automatic wait_key_ready();
    for (int i = 0; i < 40 && !key_ready; i++) tick();
    chki("key_ready_wait", int'(key_ready), 1);
  endtask

  // Expected transfers for a block accepted at t0, where pat[k] is rk_ready
  // in cycle t0+1+k.  Returns the number of cycles until the last transfer.
  function automatic int push_block(input int t0, input logic [63:0] pat);
    int k, ones;
    k = 0; ones = 0;
    while (ones < 11) begin
      if (pat[k]) begin
        q_rk.push_back('{idx: 10 - ones, data: exp_rk[10 - ones], cyc: t0 + 1 + k});
        ones++;
      end
      k++;
    end
    q_done.push_back(t0 + 1 + k);
    return k;
  endfunction

  task automatic run_block(input logic [63:0] pat);
    int t0, n;
    t0 = cyc;
    dec_start = 1'b1;
    n = push_block(t0, pat);
    tick();
    dec_start = 1'b0;
    for (int j = 0; j < n; j++) begin
      rk_ready = pat[j];
      tick();
    end
    rk_ready = 1'b1;
    tick();
  endtask

  initial begin : stim
    logic [7:0]  inv, s;
    logic [63:0] pat;
    int          t0;

    rst = 1'b1; key_load = 1'b0; cipher_key = '0; dec_start = 1'b0; rk_ready = 1'b1;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x] = s;
    end

    exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Reset state
    repeat (3) tick();
    chki("rst_key_ready", int'(key_ready), 0);
    chki("rst_dec_ready", int'(dec_ready), 0);
    chki("rst_rk_valid", int'(rk_valid), 0);
    chki("rst_rk_index", int'(rk_index), 0);
    chk("rst_rk_data", rk_data, '0);
    chk("rst_round_key_10", round_key_10, '0);
    chki("rst_inv_round_num", int'(inv_round_num), 0);
    chki("rst_inv_rkey_en", int'(inv_rkey_en), 0);
    chki("rst_dec_done", int'(dec_done), 0);
    rst = 1'b0;
    tick();
    chki("nokey_dec_ready", int'(dec_ready), 0);

    // Forward expansion of both test keys
    do_key_load(KEY_A, RK10_A);
    wait_key_ready();
    do_key_load(KEY_B, RK10_B);
    wait_key_ready();

    // Block with rk_ready held high
    run_block('1);

    // Block with random consumer stalls, including one on key 10
    pat = '1;
    for (int i = 0; i < 40; i++) pat[i] = ($urandom_range(0, 99) < 60);
    pat[0] = 1'b0;
    pat[5] = 1'b0;
    run_block(pat);

    // key_load while rk_index=5 is presented aborts the sequence
    t0 = cyc;
    dec_start = 1'b1;
    for (int j = 0; j < 6; j++)
      q_rk.push_back('{idx: 10 - j, data: exp_rk[10 - j], cyc: t0 + 1 + j});
    tick();
    dec_start = 1'b0;
    repeat (5) tick();
    do_key_load(KEY_A, RK10_A);
    chki("abort_rk_valid", int'(rk_valid), 0);
    chki("abort_key_ready", int'(key_ready), 0);
    wait_key_ready();

    // key_load and dec_start together: load wins; later dec_start ignored
    dec_start = 1'b1;
    do_key_load(KEY_B, RK10_B);
    dec_start = 1'b0;
    chki("both_dec_ready", int'(dec_ready), 0);
    chki("both_rk_valid", int'(rk_valid), 0);
    tick(); tick();
    dec_start = 1'b1;
    tick();
    dec_start = 1'b0;
    wait_key_ready();
    chki("expand_ignored_rk_valid", int'(rk_valid), 0);
    tick();

    // Back-to-back blocks with dec_start held high
    t0 = cyc;
    dec_start = 1'b1;
    void'(push_block(t0, '1));
    void'(push_block(t0 + 12, '1));
    repeat (13) tick();
    dec_start = 1'b0;
    repeat (13) tick();

    // Reset in the middle of a sequence
    t0 = cyc;
    dec_start = 1'b1;
    for (int j = 0; j < 4; j++)
      q_rk.push_back('{idx: 10 - j, data: exp_rk[10 - j], cyc: t0 + 1 + j});
    tick();
    dec_start = 1'b0;
    repeat (4) tick();
    rk_ready = 1'b0;
    rst = 1'b1;
    tick();
    chki("midrst_rk_valid", int'(rk_valid), 0);
    chki("midrst_key_ready", int'(key_ready), 0);
    chk("midrst_round_key_10", round_key_10, '0);
    rst = 1'b0;
    rk_ready = 1'b1;
    tick();
    chki("midrst_dec_ready", int'(dec_ready), 0);

    repeat (3) tick();
    chki("pending_rk", q_rk.size(), 0);
    chki("pending_done", q_done.size(), 0);
    chki("pending_key", q_key.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
